multi_chnnl_trig: RTL

- Parametrised N-channel trigger unit; successor to the single-channel trigger.
- Each channel evaluates five trigger conditions from its high-threshold and low-threshold comparator bits. The conditions are positive edge, negative edge, high level, low level and don't-care.
- Per-channel results combine in OR or AND mode and pass through an armed/holdoff state machine that issues one trigger per arm cycle.
- Sits between the analog-front-end comparators and the capture/RAM-queue control.
- All async inputs are synchronised in the clk domain; no comparator-clocked flops.

---
 rtl/multi_chnnl_trig_if.sv | 26 ++
 rtl/multi_chnnl_trig.sv | 137 +++++++++++++
 2 files changed

// File: rtl/multi_chnnl_trig_if.sv
// Bundle between capture control / comparators and the multi-channel trigger.
// The master side drives arm/config/comparators; the slave side is the trigger unit.
interface multi_chnnl_trig_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 8
);
  logic                  armed;
  logic                  trig_mode;
  logic [5*NUM_CH-1:0]   trig_cfg;
  logic [NUM_CH-1:0]     ch_hi;
  logic [NUM_CH-1:0]     ch_lo;
  logic                  triggered;
  logic                  trig_pulse;
  logic [NUM_CH-1:0]     trig_src;
  logic [CNT_W-1:0]      trig_cnt;

  modport master (
    output armed, trig_mode, trig_cfg, ch_hi, ch_lo,
    input  triggered, trig_pulse, trig_src, trig_cnt
  );

  modport slave (
    input  armed, trig_mode, trig_cfg, ch_hi, ch_lo,
    output triggered, trig_pulse, trig_src, trig_cnt
  );
endinterface

// File: rtl/multi_chnnl_trig.sv
// N-channel trigger: synchronised comparator edges/levels, OR/AND combine,
// armed/holdoff FSM issuing one trigger per arm cycle.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | disarmed; sticky edge flags held clear
// ARMING    | holdoff down-counter running; edges ignored
// WAIT      | sticky flags collect edges; trigger on first hit
// TRIGGERED | trigger issued; stays until armed drops
module multi_chnnl_trig #(
  parameter int NUM_CH  = 5,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  multi_chnnl_trig_if.slave bus
);

  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMING    = 2'd1,
    S_WAIT      = 2'd2,
    S_TRIGGERED = 2'd3
  } state_t;

  state_t              state;
  logic [HO_W-1:0]     ho_cnt;
  logic [NUM_CH-1:0]   hi_s1, hi_s2, hi_s3;
  logic [NUM_CH-1:0]   lo_s1, lo_s2, lo_s3;
  logic [NUM_CH-1:0]   pos_seen, neg_seen;
  logic [NUM_CH-1:0]   pos_edge, neg_edge;
  logic [NUM_CH-1:0]   m, en;
  logic                hit;
  logic                triggered_q;
  logic                trig_pulse_q;
  logic [NUM_CH-1:0]   trig_src_q;
  logic [CNT_W-1:0]    trig_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_s1 <= '0;
      hi_s2 <= '0;
      hi_s3 <= '0;
      lo_s1 <= '0;
      lo_s2 <= '0;
      lo_s3 <= '0;
    end else begin
      hi_s1 <= bus.ch_hi;
      hi_s2 <= hi_s1;
      hi_s3 <= hi_s2;
      lo_s1 <= bus.ch_lo;
      lo_s2 <= lo_s1;
      lo_s3 <= lo_s2;
    end
  end

  assign pos_edge = hi_s2 & ~hi_s3;
  assign neg_edge = ~lo_s2 & lo_s3;

  // Edges seen during holdoff are discarded: flags only accumulate in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_seen <= '0;
      neg_seen <= '0;
    end else if (state == S_IDLE || state == S_ARMING) begin
      pos_seen <= '0;
      neg_seen <= '0;
    end else if (state == S_WAIT) begin
      pos_seen <= pos_seen | pos_edge;
      neg_seen <= neg_seen | neg_edge;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign en[i] = |bus.trig_cfg[5*i +: 5];
    assign m[i]  = bus.trig_cfg[5*i]
                 | (bus.trig_cfg[5*i+1] & ~lo_s2[i])
                 | (bus.trig_cfg[5*i+2] &  hi_s2[i])
                 | (bus.trig_cfg[5*i+3] &  neg_seen[i])
                 | (bus.trig_cfg[5*i+4] &  pos_seen[i]);
  end

  assign hit = bus.trig_mode ? ((|en) & (&(m | ~en))) : (|(m & en));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ho_cnt       <= '0;
      triggered_q  <= 1'b0;
      trig_pulse_q <= 1'b0;
      trig_src_q   <= '0;
      trig_cnt_q   <= '0;
    end else begin
      trig_pulse_q <= 1'b0;
      if (!bus.armed) begin
        state       <= S_IDLE;
        triggered_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (HOLDOFF > 0) begin
              state  <= S_ARMING;
              ho_cnt <= HO_LOAD;
            end else begin
              state <= S_WAIT;
            end
          end
          S_ARMING: begin
            if (ho_cnt == '0) state <= S_WAIT;
            else              ho_cnt <= ho_cnt - 1'b1;
          end
          S_WAIT: begin
            if (hit) begin
              state        <= S_TRIGGERED;
              triggered_q  <= 1'b1;
              trig_pulse_q <= 1'b1;
              trig_src_q   <= m & en;
              if (trig_cnt_q != '1) trig_cnt_q <= trig_cnt_q + 1'b1;
            end
          end
          S_TRIGGERED: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.triggered  = triggered_q;
  assign bus.trig_pulse = trig_pulse_q;
  assign bus.trig_src   = trig_src_q;
  assign bus.trig_cnt   = trig_cnt_q;

endmodule
